// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW + 1)'(AE_LEVEL);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;
    logic mem_we;

    // Status is decoded from the registered pointers only, never from this
    // cycle's requests, so acceptance always reflects the pre-edge state.
    assign count        = wptr_q - rptr_q;
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign mem_we = wr_acc && !clear && !reset;

    // Handshake: wr_en/rd_en are requests accepted only when not full/empty;
    // rd_valid is a one-cycle strobe marking rd_data as a freshly popped word.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wptr_d    = '0;
            rptr_d    = '0;
            rd_data_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end else if (wr_en) begin
                overflow_d = 1'b1;
            end
            if (rd_acc) begin
                rptr_d     = rptr_q + PTR_ONE;
                rd_data_d  = mem_q[rptr_q[AW-1:0]];
                rd_valid_d = 1'b1;
            end else if (rd_en) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and randomized checks of sync_fifo_param (DEPTH=4) against a
// queue-based reference model of the FIFO's observable behaviour.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = DEPTH - 2;
    localparam int AEL   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic clr, input logic wr,
                                input logic [DW-1:0] wd, input logic rd);
        int  n;
        bit  w_ok;
        bit  r_ok;
        n = exp_q.size();
        if (rst) begin
            exp_q.delete();
            m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (clr) begin
            exp_q.delete();
            m_rd_data = '0; m_rd_valid = 1'b0;
        end else begin
            w_ok = wr && (n < DEPTH);
            r_ok = rd && (n > 0);
            if (wr && !w_ok) m_ovf = 1'b1;
            if (rd && !r_ok) m_udf = 1'b1;
            m_rd_valid = r_ok;
            if (r_ok) m_rd_data = exp_q.pop_front();
            if (w_ok) exp_q.push_back(wd);
        end
    endtask

    task automatic check_all(input string where);
        int n;
        n = exp_q.size();
        chk({where, ":rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
        chk({where, ":rd_data"}, 32'(rd_data), 32'(m_rd_data));
        chk({where, ":count"}, 32'(count), 32'(n));
        chk({where, ":empty"}, 32'(empty), 32'(n == 0));
        chk({where, ":full"}, 32'(full), 32'(n == DEPTH));
        chk({where, ":almost_full"}, 32'(almost_full), 32'(n >= AFL));
        chk({where, ":almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
        chk({where, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({where, ":underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, check.
    task automatic step(input string where, input logic rst, input logic clr,
                        input logic wr, input logic [DW-1:0] wd, input logic rd);
        reset = rst; clear = clr; wr_en = wr; wr_data = wd; rd_en = rd;
        @(posedge clk);
        model_update(rst, clr, wr, wd, rd);
        #1;
        check_all(where);
    endtask

    initial begin
        logic [DW-1:0] wd;
        bit            wr;
        bit            rd;

        // Reset
        step("reset0", 1, 0, 0, 8'h00, 0);
        step("reset1", 1, 0, 1, 8'hEE, 1);
        chk("reset:rd_data_zero", 32'(rd_data), 32'h0);
        chk("reset:empty_one", 32'(empty), 32'h1);

        // Fill, then one write too many
        step("fill1", 0, 0, 1, 8'h11, 0);
        step("fill2", 0, 0, 1, 8'h22, 0);
        step("fill3", 0, 0, 1, 8'h33, 0);
        step("fill4", 0, 0, 1, 8'h44, 0);
        chk("fill4:count_is_4", 32'(count), 32'd4);
        step("fill5", 0, 0, 1, 8'h55, 0);
        chk("fill5:overflow_set", 32'(overflow), 32'h1);

        // Drain with rd_en held 5 cycles
        step("drain1", 0, 0, 0, 8'h00, 1);
        chk("drain1:word", 32'(rd_data), 32'h11);
        step("drain2", 0, 0, 0, 8'h00, 1);
        step("drain3", 0, 0, 0, 8'h00, 1);
        step("drain4", 0, 0, 0, 8'h00, 1);
        chk("drain4:word", 32'(rd_data), 32'h44);
        step("drain5", 0, 0, 0, 8'h00, 1);
        chk("drain5:underflow_set", 32'(underflow), 32'h1);
        chk("drain5:rd_data_held", 32'(rd_data), 32'h44);

        // Simultaneous read and write at count=2
        step("sim_pre1", 0, 0, 1, 8'hB1, 0);
        step("sim_pre2", 0, 0, 1, 8'hB2, 0);
        step("sim1", 0, 0, 1, 8'hA0, 1);
        chk("sim1:word", 32'(rd_data), 32'hB1);
        step("sim2", 0, 0, 1, 8'hA0, 1);
        chk("sim2:word", 32'(rd_data), 32'hB2);
        step("sim3", 0, 0, 1, 8'hA0, 1);
        chk("sim3:word", 32'(rd_data), 32'hA0);
        chk("sim3:count", 32'(count), 32'd2);

        // Stream 0x01..0x0A through the FIFO across pointer wrap
        step("strm_rst", 1, 0, 0, 8'h00, 0);
        step("strm_w1", 0, 0, 1, 8'h01, 0);
        step("strm_w2", 0, 0, 1, 8'h02, 0);
        for (int i = 3; i <= 10; i++) begin
            step($sformatf("strm_rw%0d", i), 0, 0, 1, DW'(i), 1);
            chk($sformatf("strm_rw%0d:word", i), 32'(rd_data), 32'(i - 2));
        end
        step("strm_r9", 0, 0, 0, 8'h00, 1);
        chk("strm_r9:word", 32'(rd_data), 32'h09);
        step("strm_r10", 0, 0, 0, 8'h00, 1);
        chk("strm_r10:word", 32'(rd_data), 32'h0A);
        chk("strm:no_overflow", 32'(overflow), 32'h0);
        chk("strm:no_underflow", 32'(underflow), 32'h0);

        // Clear with count=3 and overflow set; then reset clears the flag
        for (int i = 0; i < 5; i++) step("clr_fill", 0, 0, 1, DW'(8'hC0 + i), 0);
        step("clr_pop", 0, 0, 0, 8'h00, 1);
        chk("clr_pre:count3", 32'(count), 32'd3);
        step("clr", 0, 1, 1, 8'hDD, 1);
        chk("clr:overflow_kept", 32'(overflow), 32'h1);
        chk("clr:count0", 32'(count), 32'd0);
        step("clr_after", 0, 0, 0, 8'h00, 1);
        step("clr_rst", 1, 0, 0, 8'h00, 0);
        chk("clr_rst:overflow_cleared", 32'(overflow), 32'h0);

        // Randomized traffic with occasional clear/reset
        for (int i = 0; i < 400; i++) begin
            wd = DW'($urandom);
            wr = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            step("rand", ($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0), wr, wd, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
